// File: rtl/systolic_mxu.sv
// Output-stationary ROWS x COLS systolic matrix unit.
// Skewed operand intake, accumulate mode and a back-pressured column drain.
module systolic_mxu #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int KW    = 16,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  acc_i,
  input  logic [KW-1:0]         k_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [ROWS*DW-1:0]    opa_i,
  input  logic [COLS*DW-1:0]    opb_i,
  output logic                  p_valid_o,
  input  logic                  p_ready_i,
  output logic [CW-1:0]         p_col_o,
  output logic [ROWS*ACC_W-1:0] p_word_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int FCW = $clog2(ROWS + COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                      hs, adv, clr;
  logic                      last_beat, flush_end;
  logic                      p_hs, last_col;
  logic [KW-1:0]             k_q, beat_q;
  logic [FCW-1:0]            fl_q;
  logic [CW-1:0]             col_q, col_sel;
  logic                      pv_q, fin_q;
  logic [ROWS*ACC_W-1:0]     pw_q, col_word;
  logic [ROWS*COLS*ACC_W-1:0] acc_flat;
  logic [ROWS*COLS*DW-1:0]   a_bus, b_bus;
  logic [ROWS*DW-1:0]        a_inj;
  logic [COLS*DW-1:0]        b_inj;

  assign hs        = op_valid_i & (state_q == S_FEED);
  assign adv       = (state_q == S_FEED) | (state_q == S_FLUSH);
  assign clr       = (state_q == S_IDLE) & start_i & ~acc_i;
  assign last_beat = (beat_q == k_q - KW'(1));
  assign flush_end = (fl_q == FCW'(ROWS + COLS - 2));
  assign p_hs      = pv_q & p_ready_i;
  assign last_col  = (col_q == CW'(COLS - 1));

  // Bubbles inject zero lanes so a gap never adds to any sum
  assign a_inj = hs ? opa_i : '0;
  assign b_inj = hs ? opb_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    op_ready_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i)
          state_d = (k_i == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        op_ready_o = 1'b1;
        if (op_valid_i && last_beat) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fin_q) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_sel = col_q;
    if (pv_q && !last_col) col_sel = col_q + CW'(1);
  end

  always_comb begin
    col_word = '0;
    for (int r = 0; r < ROWS; r++)
      col_word[r*ACC_W +: ACC_W] =
        acc_flat[(r*COLS + int'(col_sel))*ACC_W +: ACC_W];
  end

  // Drain prefetches column 0, then reloads on every handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q    <= '0;
      beat_q <= '0;
      fl_q   <= '0;
      col_q  <= '0;
      pv_q   <= 1'b0;
      fin_q  <= 1'b0;
      pw_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            k_q    <= k_i;
            beat_q <= '0;
            fl_q   <= '0;
            col_q  <= '0;
          end
        end
        S_FEED: begin
          if (hs) beat_q <= beat_q + KW'(1);
        end
        S_FLUSH: begin
          fl_q <= fl_q + FCW'(1);
        end
        S_DRAIN: begin
          if (!pv_q && !fin_q) begin
            pv_q <= 1'b1;
            pw_q <= col_word;
          end else if (p_hs) begin
            if (last_col) begin
              pv_q  <= 1'b0;
              pw_q  <= '0;
              fin_q <= 1'b1;
            end else begin
              col_q <= col_q + CW'(1);
              pw_q  <= col_word;
            end
          end
        end
        S_DONE: begin
          col_q <= '0;
          fin_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign p_valid_o = pv_q;
  assign p_word_o  = pw_q;
  assign p_col_o   = col_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_bus[0 +: DW] = a_inj[0 +: DW];
    end else begin : g_chain
      logic [DW-1:0] sk_q [r];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else if (adv) begin
          sk_q[0] <= a_inj[r*DW +: DW];
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign a_bus[r*COLS*DW +: DW] = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_bus[0 +: DW] = b_inj[0 +: DW];
    end else begin : g_chain
      logic [DW-1:0] sk_q [c];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < c; i++) sk_q[i] <= '0;
        end else if (adv) begin
          sk_q[0] <= b_inj[c*DW +: DW];
          for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign b_bus[c*DW +: DW] = sk_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [DW-1:0]   a_w, b_w;
      logic signed [2*DW-1:0] prod;
      logic [ACC_W-1:0]       acc_q;

      assign a_w  = a_bus[(r*COLS + c)*DW +: DW];
      assign b_w  = b_bus[(r*COLS + c)*DW +: DW];
      assign prod = a_w * b_w;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  acc_q <= '0;
        else if (clr) acc_q <= '0;
        else if (adv) acc_q <= acc_q + ACC_W'(prod);
      end

      assign acc_flat[(r*COLS + c)*ACC_W +: ACC_W] = acc_q;

      if (c < COLS - 1) begin : g_apass
        logic [DW-1:0] a_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni)  a_q <= '0;
          else if (adv) a_q <= a_w;
        end
        assign a_bus[(r*COLS + c + 1)*DW +: DW] = a_q;
      end

      if (r < ROWS - 1) begin : g_bpass
        logic [DW-1:0] b_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni)  b_q <= '0;
          else if (adv) b_q <= b_w;
        end
        assign b_bus[((r+1)*COLS + c)*DW +: DW] = b_q;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mxu.sv
// Bench for systolic_mxu: directed tiles, scoreboard of expected columns,
// one 32-bit and one 16-bit accumulator instance driven in lockstep.
module tb_systolic_mxu;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int KW = 16;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            acc_i = 1'b0;
  logic [KW-1:0]   k_i = '0;
  logic            op_valid_i = 1'b0;
  logic [R*DW-1:0] opa_i = '0;
  logic [C*DW-1:0] opb_i = '0;
  logic            p_ready_i = 1'b1;

  logic            op_ready_o, p_valid_o, busy_o, done_o;
  logic [1:0]      p_col_o;
  logic [R*32-1:0] p_word_o;
  logic            op_ready16, p_valid16, busy16, done16;
  logic [1:0]      p_col16;
  logic [R*16-1:0] p_word16;

  systolic_mxu #(.ROWS(R), .COLS(C), .DW(DW), .ACC_W(32), .KW(KW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .acc_i(acc_i),
    .k_i(k_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .opa_i(opa_i), .opb_i(opb_i), .p_valid_o(p_valid_o),
    .p_ready_i(p_ready_i), .p_col_o(p_col_o), .p_word_o(p_word_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  systolic_mxu #(.ROWS(R), .COLS(C), .DW(DW), .ACC_W(16), .KW(KW)) dut16 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .acc_i(acc_i),
    .k_i(k_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready16),
    .opa_i(opa_i), .opb_i(opb_i), .p_valid_o(p_valid16),
    .p_ready_i(p_ready_i), .p_col_o(p_col16), .p_word_o(p_word16),
    .busy_o(busy16), .done_o(done16)
  );

  always #5 clk = ~clk;

  int ntot = 0;
  int npass = 0;
  int ta [R][16];
  int tb [16][C];
  longint mdl [R][C];
  logic [R*32-1:0] sbq [$];
  logic [R*16-1:0] sbq16 [$];
  int sbc [$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic set_ident();
    for (int r = 0; r < R; r++)
      for (int k = 0; k < 16; k++) ta[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < 16; k++)
      for (int c = 0; c < C; c++) tb[k][c] = 4*k + c + 1;
  endtask

  task automatic set_const(input int v);
    for (int r = 0; r < R; r++)
      for (int k = 0; k < 16; k++) ta[r][k] = v;
    for (int k = 0; k < 16; k++)
      for (int c = 0; c < C; c++) tb[k][c] = v;
  endtask

  task automatic push_model(input bit accm, input int k);
    logic [R*32-1:0] w32;
    logic [R*16-1:0] w16;
    if (!accm)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) mdl[r][c] = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int kk = 0; kk < k; kk++)
          mdl[r][c] += longint'(ta[r][kk]) * longint'(tb[kk][c]);
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < R; r++) begin
        w32[r*32 +: 32] = 32'(mdl[r][c]);
        w16[r*16 +: 16] = 16'(mdl[r][c]);
      end
      sbq.push_back(w32);
      sbq16.push_back(w16);
      sbc.push_back(c);
    end
  endtask

  task automatic drive_beat(input int kk);
    for (int r = 0; r < R; r++) opa_i[r*DW +: DW] = DW'(ta[r][kk]);
    for (int c = 0; c < C; c++) opb_i[c*DW +: DW] = DW'(tb[kk][c]);
  endtask

  task automatic run_tile(input bit accm, input int k,
                          input int gap_after, input int gap_len,
                          input int stall_col, input int stall_len,
                          input bit poke);
    int cyc, beat, gap, g, first_v, ec;
    logic [R*32-1:0] e32;
    logic [R*16-1:0] e16;
    @(negedge clk);
    start_i = 1'b1; acc_i = accm; k_i = KW'(k);
    push_model(accm, k);
    @(negedge clk);
    start_i = 1'b0; acc_i = 1'b0; k_i = '0;
    cyc = 1; beat = 0; gap = 0;
    while (beat < k && cyc < 200) begin
      if (poke && cyc == 2) begin start_i = 1'b1; k_i = KW'(1); end
      else begin start_i = 1'b0; k_i = '0; end
      if (beat == gap_after + 1 && gap < gap_len) begin
        op_valid_i = 1'b0; gap++;
      end else begin
        op_valid_i = 1'b1; drive_beat(beat);
      end
      chk("op_ready", op_ready_o, 1);
      if (op_valid_i && op_ready_o) beat++;
      @(negedge clk); cyc++;
    end
    op_valid_i = 1'b0; start_i = 1'b0; k_i = '0;
    g = 0;
    while (!p_valid_o && g < 100) begin @(negedge clk); cyc++; g++; end
    chk("valid_seen", p_valid_o, 1);
    first_v = cyc;
    if (k > 0 && gap_len == 0) chk("first_lat", cyc, k + R + C + 1);
    for (int col = 0; col < C; col++) begin
      e32 = sbq.pop_front(); e16 = sbq16.pop_front(); ec = sbc.pop_front();
      chk("p_valid", p_valid_o, 1);
      chk("p_col", p_col_o, ec);
      chk("p_word", p_word_o, e32);
      chk("p_word16", p_word16, e16);
      if (col == stall_col) begin
        p_ready_i = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          @(negedge clk); cyc++;
          chk("hold_valid", p_valid_o, 1);
          chk("hold_col", p_col_o, ec);
          chk("hold_word", p_word_o, e32);
        end
        p_ready_i = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    chk("valid_off", p_valid_o, 0);
    g = 0;
    while (!done_o && g < 20) begin @(negedge clk); cyc++; g++; end
    chk("done", done_o, 1);
    if (k > 0 && gap_len == 0 && stall_len == 0)
      chk("done_lat", cyc, first_v + C + 1);
    @(negedge clk);
    chk("done_pulse", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_word", p_word_o, 0);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    int g;
    repeat (2) @(negedge clk);
    chk("rst_valid", p_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", op_ready_o, 0);
    chk("rst_col", p_col_o, 0);
    chk("rst_word", p_word_o, 0);
    chk("rst_busy16", busy16, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    set_ident();
    run_tile(1'b0, 4, -1, 0, -1, 0, 1'b0);
    run_tile(1'b1, 4, -1, 0, -1, 0, 1'b0);
    run_tile(1'b0, 4, -1, 0, 1, 5, 1'b0);
    run_tile(1'b0, 4, 1, 3, -1, 0, 1'b0);
    set_const(-128);
    run_tile(1'b0, 4, -1, 0, -1, 0, 1'b0);

    set_ident();
    @(negedge clk);
    start_i = 1'b1; acc_i = 1'b0; k_i = KW'(4);
    @(negedge clk);
    start_i = 1'b0; k_i = '0;
    for (int kk = 0; kk < 4; kk++) begin
      op_valid_i = 1'b1; drive_beat(kk);
      @(negedge clk);
    end
    op_valid_i = 1'b0;
    g = 0;
    while (!(p_valid_o && p_col_o == 2'd2) && g < 100) begin
      @(negedge clk); g++;
    end
    chk("abort_col", p_col_o, 2);
    rst_ni = 1'b0;
    #1;
    chk("abort_valid", p_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_word", p_word_o, 0);
    @(negedge clk);
    chk("abort_nodone", done_o, 0);
    rst_ni = 1'b1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mdl[r][c] = 0;
    run_tile(1'b1, 0, -1, 0, -1, 0, 1'b0);
    run_tile(1'b0, 4, -1, 0, -1, 0, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
